mont_mul_param: RTL

MONT_MUL_PARAM -- requirements
Module: mont_mul_param

---
 rtl/mont_mul_param.sv | 111 +++++++++++
 1 files changed

// File: rtl/mont_mul_param.sv
// Bit-serial Montgomery multiplier: v_o = a*b*2^-W mod n, one multiplier bit per cycle.
// Define MONT_MUL_FINAL_SUB_EN to add a final conditional subtraction so that v_o < n.
module mont_mul_param #(
  parameter int unsigned W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] n_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         valid_o,
  output logic [W-1:0] v_o
);

  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StCalc, StSub, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   n_q, n_d, a_q, a_d, b_q, b_d, v_o_q, v_o_d;
  logic [W+1:0]   v_q, v_d, v_step;
  logic [CntW-1:0] i_q, i_d;
  logic [W+2:0]   t;
`ifdef MONT_MUL_FINAL_SUB_EN
  logic [W+1:0]   v_red;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    a_d     = a_q;
    b_d     = b_q;
    v_d     = v_q;
    i_d     = i_q;
    v_o_d   = v_o_q;

    // a_q is shifted right each CALC cycle, so a_q[0] is always the current multiplier bit.
    t = {1'b0, v_q} + (a_q[0] ? {3'b000, b_q} : '0);
    if (t[0]) begin
      t = t + {3'b000, n_q};
    end
    v_step = t[W+2:1];
`ifdef MONT_MUL_FINAL_SUB_EN
    v_red = (v_q >= {2'b00, n_q}) ? (v_q - {2'b00, n_q}) : v_q;
`endif

    case (state_q)
      StIdle: begin
        if (start_i) begin
          n_d     = n_i;
          a_d     = a_i;
          b_d     = b_i;
          v_d     = '0;
          i_d     = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        v_d = v_step;
        a_d = a_q >> 1;
        i_d = i_q + 1'b1;
        if (i_q == CntW'(W - 1)) begin
`ifdef MONT_MUL_FINAL_SUB_EN
          state_d = StSub;
`else
          v_o_d   = v_step[W-1:0];
          state_d = StDone;
`endif
        end
      end
`ifdef MONT_MUL_FINAL_SUB_EN
      StSub: begin
        v_d     = v_red;
        v_o_d   = v_red[W-1:0];
        state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      v_q     <= '0;
      i_q     <= '0;
      v_o_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v_q     <= v_d;
      i_q     <= i_d;
      v_o_q   <= v_o_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign busy_o  = ~ready_o;
  assign valid_o = (state_q == StDone);
  assign v_o     = v_o_q;

endmodule
